// File: rtl/ram_packet_buffer_if.sv
// Stream-in / packet-read-out bundle for ram_packet_buffer.
// The master drives the word stream and read requests; the buffer is the slave.
interface ram_packet_buffer_if #(
  parameter int DATA_W    = 32,
  parameter int NUM_SLOTS = 4
);
  localparam int CNT_W = $clog2(NUM_SLOTS) + 1;

  logic              i_data_valid;
  logic [DATA_W-1:0] i_data;
  logic              i_rd_start;
  logic              o_pkt_avail;
  logic [CNT_W-1:0]  o_pkt_count;
  logic              o_rd_busy;
  logic              o_rd_valid;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_overflow;
  logic [15:0]       o_drop_count;

  modport master (
    output i_data_valid, i_data, i_rd_start,
    input  o_pkt_avail, o_pkt_count, o_rd_busy, o_rd_valid, o_rd_data,
           o_overflow, o_drop_count
  );

  modport slave (
    input  i_data_valid, i_data, i_rd_start,
    output o_pkt_avail, o_pkt_count, o_rd_busy, o_rd_valid, o_rd_data,
           o_overflow, o_drop_count
  );
endinterface

// File: rtl/ram_packet_buffer.sv
// Packetising ring buffer: groups PKT_LEN valid words into RAM slots and
// streams the oldest stored packet back out on request; packets with no free slot are dropped.
module ram_packet_buffer #(
  parameter int DATA_W    = 32,
  parameter int PKT_LEN   = 64,
  parameter int NUM_SLOTS = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  ram_packet_buffer_if.slave bus
);
  localparam int PKT_W  = $clog2(PKT_LEN);
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int CNT_W  = SLOT_W + 1;
  localparam int ADDR_W = SLOT_W + PKT_W;
  localparam int DEPTH  = NUM_SLOTS * PKT_LEN;

  typedef enum logic [1:0] {WR_IDLE, WR_STORE, WR_DROP} wrState_t;
  typedef enum logic       {RD_IDLE, RD_READ}           rdState_t;

  wrState_t          r_wrState, w_wrNext;
  logic [PKT_W-1:0]  r_wrCnt;
  logic [SLOT_W-1:0] r_wrSlot;
  logic              w_wrEn, w_wrLast, w_commit, w_dropStart;
  logic [ADDR_W-1:0] w_wrAddr;

  rdState_t          r_rdState, w_rdNext;
  logic [PKT_W:0]    r_rdCnt;
  logic [SLOT_W-1:0] r_rdSlot;
  logic              w_rdAccept, w_rdEn, w_release;
  logic [ADDR_W-1:0] w_rdAddr;

  logic [CNT_W-1:0]  r_pktCount, w_pktCountNext;
  logic              r_pktAvail;
  logic              r_overflow;
  logic [15:0]       r_dropCount;
  logic              r_rdValid;
  logic [DATA_W-1:0] r_rdData;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  // Slots are PKT_LEN words and PKT_LEN is a power of two, so slot/offset concatenate into an address.
  assign w_wrAddr = {r_wrSlot, r_wrCnt};
  assign w_rdAddr = {r_rdSlot, r_rdCnt[PKT_W-1:0]};
  assign w_wrLast = bus.i_data_valid && (r_wrCnt == PKT_W'(PKT_LEN - 1));

  always_comb begin
    w_wrNext    = r_wrState;
    w_wrEn      = 1'b0;
    w_commit    = 1'b0;
    w_dropStart = 1'b0;
    case (r_wrState)
      WR_IDLE: begin
        if (bus.i_data_valid) begin
          if (r_pktCount < CNT_W'(NUM_SLOTS)) begin
            w_wrEn   = 1'b1;
            w_wrNext = WR_STORE;
          end else begin
            w_dropStart = 1'b1;
            w_wrNext    = WR_DROP;
          end
        end
      end
      WR_STORE: begin
        if (bus.i_data_valid) begin
          w_wrEn = 1'b1;
          if (w_wrLast) begin
            w_commit = 1'b1;
            w_wrNext = WR_IDLE;
          end
        end
      end
      WR_DROP: begin
        if (w_wrLast) w_wrNext = WR_IDLE;
      end
      default: w_wrNext = WR_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrState   <= WR_IDLE;
      r_wrCnt     <= '0;
      r_wrSlot    <= '0;
      r_overflow  <= 1'b0;
      r_dropCount <= '0;
    end else begin
      r_wrState  <= w_wrNext;
      r_overflow <= w_dropStart;
      if (bus.i_data_valid) r_wrCnt <= r_wrCnt + PKT_W'(1);
      if (w_commit) r_wrSlot <= r_wrSlot + SLOT_W'(1);
      if (w_dropStart && (r_dropCount != 16'hFFFF)) r_dropCount <= r_dropCount + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wrEn) r_mem[w_wrAddr] <= bus.i_data;
  end

  // r_rdCnt runs one past the last offset; that extra cycle drains the synchronous RAM read.
  assign w_rdAccept = (r_rdState == RD_IDLE) && bus.i_rd_start && r_pktAvail;
  assign w_rdEn     = (r_rdState == RD_READ) && !r_rdCnt[PKT_W];
  assign w_release  = w_rdEn && (r_rdCnt[PKT_W-1:0] == PKT_W'(PKT_LEN - 1));

  always_comb begin
    w_rdNext = r_rdState;
    case (r_rdState)
      RD_IDLE: if (w_rdAccept) w_rdNext = RD_READ;
      RD_READ: if (r_rdCnt[PKT_W]) w_rdNext = RD_IDLE;
      default: w_rdNext = RD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdState <= RD_IDLE;
      r_rdCnt   <= '0;
      r_rdSlot  <= '0;
      r_rdValid <= 1'b0;
      r_rdData  <= '0;
    end else begin
      r_rdState <= w_rdNext;
      r_rdValid <= w_rdEn;
      if (w_rdAccept) r_rdCnt <= '0;
      else if (w_rdEn) r_rdCnt <= r_rdCnt + (PKT_W + 1)'(1);
      if (w_release) r_rdSlot <= r_rdSlot + SLOT_W'(1);
      if (w_rdEn) r_rdData <= r_mem[w_rdAddr];
    end
  end

  // A commit and a release in the same cycle cancel out.
  always_comb begin
    w_pktCountNext = r_pktCount;
    if (w_commit && !w_release) w_pktCountNext = r_pktCount + CNT_W'(1);
    else if (!w_commit && w_release) w_pktCountNext = r_pktCount - CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pktCount <= '0;
      r_pktAvail <= 1'b0;
    end else begin
      r_pktCount <= w_pktCountNext;
      r_pktAvail <= (w_pktCountNext != '0);
    end
  end

  assign bus.o_pkt_avail  = r_pktAvail;
  assign bus.o_pkt_count  = r_pktCount;
  assign bus.o_rd_busy    = (r_rdState == RD_READ);
  assign bus.o_rd_valid   = r_rdValid;
  assign bus.o_rd_data    = r_rdData;
  assign bus.o_overflow   = r_overflow;
  assign bus.o_drop_count = r_dropCount;
endmodule

// File: tb/tb_ram_packet_buffer.sv
// Bench for ram_packet_buffer: a packet-queue model predicts every output each cycle,
// and directed scenarios add literal expectations at key points.
module tb_ram_packet_buffer;
  localparam int DATA_W    = 32;
  localparam int PKT_LEN   = 64;
  localparam int NUM_SLOTS = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_packet_buffer_if #(.DATA_W(DATA_W), .NUM_SLOTS(NUM_SLOTS)) bus ();

  ram_packet_buffer #(.DATA_W(DATA_W), .PKT_LEN(PKT_LEN), .NUM_SLOTS(NUM_SLOTS)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int rdValidCycles = 0;
  int ovfPulses = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: words collect into a pending packet; committed packets join a FIFO of words;
  // a read takes the oldest packet and plays it out at fixed offsets from the start cycle.
  int          mWordIdx;
  bit          mDropping;
  logic [31:0] mPend[$];
  logic [31:0] mStore[$];
  logic [31:0] mRdBuf[PKT_LEN];
  int          mRdK;
  int          eCount, eDrop;
  bit          eBusy, eValid, eOvf;
  logic [31:0] eData;
  int          commitN, relN;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mWordIdx = 0; mDropping = 0; mPend.delete(); mStore.delete(); mRdK = 0;
      eCount = 0; eDrop = 0; eBusy = 0; eValid = 0; eOvf = 0; eData = 0;
    end else begin
      commitN = 0; relN = 0; eOvf = 0;
      if (mRdK > 0) begin
        if (mRdK == PKT_LEN) relN = 1;
        mRdK = (mRdK == PKT_LEN + 1) ? 0 : mRdK + 1;
      end else if (bus.i_rd_start && eCount > 0) begin
        for (int i = 0; i < PKT_LEN; i++) mRdBuf[i] = mStore.pop_front();
        mRdK = 1;
      end
      eBusy  = (mRdK > 0);
      eValid = (mRdK >= 2);
      if (eValid) eData = mRdBuf[mRdK-2];
      if (bus.i_data_valid) begin
        if (mWordIdx == 0) begin
          mDropping = (eCount >= NUM_SLOTS);
          if (mDropping) begin
            eOvf = 1;
            if (eDrop < 65535) eDrop++;
          end
        end
        if (!mDropping) mPend.push_back(bus.i_data);
        mWordIdx++;
        if (mWordIdx == PKT_LEN) begin
          mWordIdx = 0;
          if (!mDropping) begin
            foreach (mPend[i]) mStore.push_back(mPend[i]);
            commitN = 1;
          end
          mPend.delete();
        end
      end
      eCount = eCount + commitN - relN;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("cyc_pkt_count", 32'(bus.o_pkt_count), eCount);
      checkOutput("cyc_pkt_avail", 32'(bus.o_pkt_avail), (eCount != 0));
      checkOutput("cyc_rd_busy",   32'(bus.o_rd_busy), eBusy);
      checkOutput("cyc_rd_valid",  32'(bus.o_rd_valid), eValid);
      checkOutput("cyc_rd_data",   bus.o_rd_data, eData);
      checkOutput("cyc_overflow",  32'(bus.o_overflow), eOvf);
      checkOutput("cyc_drop_count", 32'(bus.o_drop_count), eDrop);
      if (bus.o_rd_valid) rdValidCycles++;
      if (bus.o_overflow) ovfPulses++;
    end
  end

  task automatic applyStimulus(input int base, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.i_data_valid = 1'b1;
      bus.i_data = 32'(base + i);
      if (gap) begin
        @(negedge clk);
        bus.i_data_valid = 1'b0;
      end
    end
    @(negedge clk);
    bus.i_data_valid = 1'b0;
  endtask

  task automatic driveWord(input int v);
    @(negedge clk);
    bus.i_data_valid = 1'b1;
    bus.i_data = 32'(v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseStart();
    @(negedge clk);
    bus.i_rd_start = 1'b1;
    @(negedge clk);
    bus.i_rd_start = 1'b0;
  endtask

  task automatic waitNotBusy(input int limit);
    int k = 0;
    while (bus.o_rd_busy === 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (k >= limit) begin
      checks++;
      failures++;
      $display("[TB] FAIL wait_not_busy actual=timeout required=idle t=%0t", $time);
    end
  endtask

  task automatic readOne();
    pulseStart();
    waitNotBusy(PKT_LEN + 10);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_count"}, 32'(bus.o_pkt_count), 0);
    checkOutput({tag, "_avail"}, 32'(bus.o_pkt_avail), 0);
    checkOutput({tag, "_busy"},  32'(bus.o_rd_busy), 0);
    checkOutput({tag, "_valid"}, 32'(bus.o_rd_valid), 0);
    checkOutput({tag, "_data"},  bus.o_rd_data, 0);
    checkOutput({tag, "_ovf"},   32'(bus.o_overflow), 0);
    checkOutput({tag, "_drop"},  32'(bus.o_drop_count), 0);
  endtask

  initial begin
    bus.i_data_valid = 1'b0;
    bus.i_data = '0;
    bus.i_rd_start = 1'b0;
    #1 rst = 1'b1;
    idle(3);
    checkResetOutputs("reset");
    rst = 1'b0;

    $display("[TB] single packet");
    applyStimulus(0, 64, 0);
    idle(2);
    checkOutput("s1_count", 32'(bus.o_pkt_count), 1);
    checkOutput("s1_avail", 32'(bus.o_pkt_avail), 1);
    rdValidCycles = 0;
    pulseStart();
    checkOutput("s1_busy_t1", 32'(bus.o_rd_busy), 1);
    checkOutput("s1_valid_t1", 32'(bus.o_rd_valid), 0);
    @(negedge clk);
    checkOutput("s1_valid_t2", 32'(bus.o_rd_valid), 1);
    checkOutput("s1_first_word", bus.o_rd_data, 0);
    waitNotBusy(PKT_LEN + 10);
    idle(2);
    checkOutput("s1_valid_cycles", rdValidCycles, 64);
    checkOutput("s1_count_after", 32'(bus.o_pkt_count), 0);
    checkOutput("s1_last_word", bus.o_rd_data, 63);

    $display("[TB] back-to-back");
    ovfPulses = 0;
    applyStimulus(0, 128, 0);
    idle(2);
    checkOutput("s2_count", 32'(bus.o_pkt_count), 2);
    readOne();
    readOne();
    idle(2);
    checkOutput("s2_last_word", bus.o_rd_data, 127);
    checkOutput("s2_count_after", 32'(bus.o_pkt_count), 0);
    checkOutput("s2_ovf_pulses", ovfPulses, 0);

    $display("[TB] overflow");
    ovfPulses = 0;
    applyStimulus(0, 320, 0);
    idle(2);
    checkOutput("s3_count", 32'(bus.o_pkt_count), 4);
    checkOutput("s3_drop", 32'(bus.o_drop_count), 1);
    checkOutput("s3_ovf_pulses", ovfPulses, 1);
    repeat (4) readOne();
    idle(2);
    checkOutput("s3_last_word", bus.o_rd_data, 255);
    checkOutput("s3_avail_after", 32'(bus.o_pkt_avail), 0);

    $display("[TB] concurrent read and write");
    ovfPulses = 0;
    applyStimulus(1000, 192, 0);
    for (int i = 0; i < 64; i++) driveWord(1192 + i);
    @(negedge clk);
    bus.i_data_valid = 1'b0;
    bus.i_rd_start = 1'b1;
    @(negedge clk);
    bus.i_rd_start = 1'b0;
    idle(63);
    for (int i = 0; i < 64; i++) driveWord(2000 + i);
    @(negedge clk);
    bus.i_data_valid = 1'b0;
    waitNotBusy(PKT_LEN + 10);
    idle(2);
    checkOutput("s4_count", 32'(bus.o_pkt_count), 4);
    checkOutput("s4_drop", 32'(bus.o_drop_count), 1);
    checkOutput("s4_ovf_pulses", ovfPulses, 0);
    repeat (4) readOne();
    idle(2);
    checkOutput("s4_last_word", bus.o_rd_data, 2063);

    $display("[TB] gapped input and ignored starts");
    pulseStart();
    checkOutput("s5_busy_empty_start", 32'(bus.o_rd_busy), 0);
    applyStimulus(3000, 63, 1);
    checkOutput("s5_count_63", 32'(bus.o_pkt_count), 0);
    applyStimulus(3063, 1, 0);
    checkOutput("s5_count_64", 32'(bus.o_pkt_count), 1);
    rdValidCycles = 0;
    pulseStart();
    idle(3);
    pulseStart();
    waitNotBusy(PKT_LEN + 10);
    idle(3);
    checkOutput("s5_busy_after", 32'(bus.o_rd_busy), 0);
    checkOutput("s5_valid_cycles", rdValidCycles, 64);
    checkOutput("s5_last_word", bus.o_rd_data, 3063);

    $display("[TB] reset mid-operation");
    applyStimulus(4000, 64, 0);
    pulseStart();
    idle(10);
    #2 rst = 1'b1;
    #1 checkResetOutputs("rst_read");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) driveWord(5000 + i);
    #2 rst = 1'b1;
    bus.i_data_valid = 1'b0;
    #1 checkResetOutputs("rst_write");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(6000, 64, 0);
    idle(2);
    checkOutput("s6_count", 32'(bus.o_pkt_count), 1);
    pulseStart();
    @(negedge clk);
    checkOutput("s6_first_word", bus.o_rd_data, 6000);
    waitNotBusy(PKT_LEN + 10);
    idle(2);
    checkOutput("s6_last_word", bus.o_rd_data, 6063);
    checkOutput("s6_count_after", 32'(bus.o_pkt_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_packet_buffer.md
Name: ram_packet_buffer

Overview:
Downstream consumer of the 32-bit incremental data generator stream. Groups every PKT_LEN valid words into one packet and writes it into an on-chip RAM organised as NUM_SLOTS packet slots, managed as a ring. Read-out is on request: a read start pulse streams one complete packet out in arrival order. Packets that arrive with no free slot are dropped and counted.

Parameters:
DATA_W, 32, data word width
PKT_LEN, 64, words per packet; power of 2
NUM_SLOTS, 4, packet slots in RAM; power of 2, ≥2; RAM depth = NUM_SLOTS*PKT_LEN

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_rst  input  1  asynchronous, active-high reset
i_data_valid  input  1  input word valid; gaps permitted
i_data  input  DATA_W  input word
i_rd_start  input  1  one-cycle request to read the oldest stored packet
o_pkt_avail  output  1  at least one complete packet stored
o_pkt_count  output  log2(NUM_SLOTS)+1  complete packets stored
o_rd_busy  output  1  read-out in progress
o_rd_valid  output  1  o_rd_data valid
o_rd_data  output  DATA_W  read-out word
o_overflow  output  1  one-cycle pulse: an incoming packet is being dropped
o_drop_count  output  16  dropped packets, saturating at 16'hFFFF

Behaviour:
- Reset: asynchronous, active-high (i_rst). Clears all registers and outputs to 0: write/read slot pointers, word counters, o_pkt_count, FSMs to IDLE. RAM contents are not cleared. A partial packet in flight is discarded. A read-out in progress is aborted; o_rd_valid drops immediately.
- Write side, FSM states WR_IDLE / WR_STORE / WR_DROP:
  - wr_cnt counts accepted valid words 0..PKT_LEN-1 and wraps to 0.
  - The first word of a packet (valid while wr_cnt==0) is classified in the same cycle.
  - If o_pkt_count < NUM_SLOTS: the word is stored and the FSM goes to WR_STORE.
  - Otherwise the word is discarded and the FSM goes to WR_DROP.
  - Stored word address = wr_slot*PKT_LEN + wr_cnt. The RAM write occurs in the cycle i_data_valid is high.
  - On the PKT_LEN-th valid word: wr_slot increments modulo NUM_SLOTS (STORE only), the FSM returns to WR_IDLE, and the packet counts as committed from the next cycle.
  - A first word arriving in the cycle right after a commit is legal. Back-to-back packets must not lose words.
  - Cycles with i_data_valid=0 hold wr_cnt and state.
- Drop: o_overflow pulses high the cycle after the first word of a dropped packet. o_drop_count increments at the same time, saturating. The rest of the dropped packet is consumed without any write.
- Read side, FSM states RD_IDLE / RD_READ:
  - i_rd_start is accepted only in RD_IDLE with o_pkt_avail=1. Otherwise it is ignored with no side effect.
  - Accepted at cycle T: o_rd_busy goes high at T+1. RAM addresses rd_slot*PKT_LEN+0..PKT_LEN-1 are issued at T+1..T+PKT_LEN.
  - RAM read is synchronous, so o_rd_valid is high T+2..T+PKT_LEN+1 with the words in order. o_rd_busy falls after T+PKT_LEN+1.
  - At T+PKT_LEN (last address issued) the slot is released: rd_slot increments modulo NUM_SLOTS and o_pkt_count decrements next cycle.
  - The writer can therefore reuse the slot from T+PKT_LEN+1 without corrupting read data.
- o_pkt_count: a commit and a release in the same cycle leave it unchanged. It never exceeds NUM_SLOTS and never underflows.
- o_pkt_avail = (o_pkt_count != 0), registered.
- o_rd_data holds its last value when o_rd_valid=0.

Test Plan:
- Single packet: 64 valid words 0..63 then idle; pulse i_rd_start -> o_pkt_count 1→0; o_rd_valid exactly 64 cycles starting 2 cycles after start; data 0..63.
- Back-to-back: 128 continuous valid words 0..127 -> o_pkt_count=2; two reads return 0..63 then 64..127; no o_overflow.
- Overflow: 5 packets (values 0..319), no reads, NUM_SLOTS=4 -> o_pkt_count=4; one o_overflow pulse; o_drop_count=1; reads return 0..255, packet 256..319 absent.
- Concurrent read/write: buffer full; i_rd_start one cycle after a packet's last word, next packet begins exactly at slot release cycle+1 -> stored, no drop, o_pkt_count stays 4 at end, data intact.
- Gapped input plus ignored start: valid toggling every other cycle for 64 words; i_rd_start pulsed while empty and while busy -> no effect; a packet commits after the 64th valid word.
- Reset mid-operation: assert i_rst at word 30 of a packet and mid read-out -> all outputs 0 asynchronously; after release the next 64 words form slot 0 and read back correctly.
